// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Hazard and stall controller for the five-stage pipelined core.
//               Produces the Stall/Flush controls for the pipeline registers,
//               the EX-stage operand forwarding selects, sequences multi-cycle
//               data-memory accesses under a watchdog and keeps free-running
//               stall/flush performance counters.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   Rs1D, Rs2D                 Decode source registers
//   Rs1E, Rs2E, RdE            Execute source/destination registers
//   ResultSrcE                 Execute result source (2'b01 = load)
//   PCSrcE                     taken branch/jump resolved in Execute
//   RdM, RdW                   Memory / Writeback destination registers
//   RegWriteM, RegWriteW       Memory / Writeback register-write enables
//   MemReqM, MemReadyM         Memory-stage access request / completion
//   StallF/D/E/M               hold PC, IF/ID, ID/EX, EX/MEM
//   FlushD/E/W                 bubble IF/ID, ID/EX, MEM/WB
//   ForwardAE, ForwardBE       00 regfile, 01 Writeback, 10 Memory ALU result
//   mem_err                    sticky memory-timeout flag
//   stall_cycles, flush_count  performance counters (wrap modulo 2^CNT_W)
//
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    // Last wait_cnt value tolerated in MEM_WAIT before declaring a timeout.
    localparam logic [15:0] C_WAIT_LAST = 16'(MEM_TIMEOUT - 1);
    localparam logic [1:0]  C_FWD_RF    = 2'b00;
    localparam logic [1:0]  C_FWD_WB    = 2'b01;
    localparam logic [1:0]  C_FWD_MEM   = 2'b10;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_wait_cnt;
    logic [15:0] w_wait_cnt_nxt;
    logic        w_mem_stall;
    logic        w_lw_stall;
    logic        w_flush_branch;

    // Memory is still busy; identical behaviour in RUN and MEM_WAIT.
    assign w_mem_stall = (r_state != ERR) & MemReqM & ~MemReadyM;

    assign w_lw_stall = (ResultSrcE == 2'b01) & (RdE != 5'd0) &
                        ((Rs1D == RdE) | (Rs2D == RdE));

    assign mem_err = (r_state == ERR);

    // Memory stage has priority over Writeback since it holds the newer value.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (RegWriteM && (RdM != 5'd0) && (RdM == rs)) begin
            return C_FWD_MEM;
        end else if (RegWriteW && (RdW != 5'd0) && (RdW == rs)) begin
            return C_FWD_WB;
        end
        return C_FWD_RF;
    endfunction

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        case (r_state)
            RUN: begin
                if (MemReqM && !MemReadyM) begin
                    w_state_nxt    = MEM_WAIT;
                    w_wait_cnt_nxt = 16'd0;
                end
            end
            MEM_WAIT: begin
                if (MemReadyM) begin
                    w_state_nxt = RUN;
                end else if (r_wait_cnt == C_WAIT_LAST) begin
                    w_state_nxt = ERR;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 16'd1;
                end
            end
            ERR: begin
                w_state_nxt = ERR;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Stall / flush / forward outputs (zero-cycle, priority encoded)
    // ------------------------------------------------------------------
    always_comb begin
        StallF         = 1'b0;
        StallD         = 1'b0;
        StallE         = 1'b0;
        StallM         = 1'b0;
        FlushD         = 1'b0;
        FlushE         = 1'b0;
        FlushW         = 1'b0;
        ForwardAE      = C_FWD_RF;
        ForwardBE      = C_FWD_RF;
        w_flush_branch = 1'b0;

        if (!rst_n) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else begin
            ForwardAE = fwd_sel(Rs1E);
            ForwardBE = fwd_sel(Rs2E);
            if ((r_state == ERR) || w_mem_stall) begin
                // Whole pipe frozen; Execute/Decode hazards wait for release.
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (PCSrcE) begin
                // Redirect squashes any load-use dependent in Decode.
                FlushD         = 1'b1;
                FlushE         = 1'b1;
                w_flush_branch = 1'b1;
            end else if (w_lw_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // State, watchdog counter and performance counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= RUN;
            r_wait_cnt   <= 16'd0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (StallF) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (w_flush_branch) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and stall controller for the five-stage pipelined core. It drives the Stall/Flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, produces the EX-stage operand forwarding selects, and sequences multi-cycle data-memory accesses with a watchdog. It also keeps free-running stall and flush performance counters.

## Interface
- MEM_TIMEOUT, 255: maximum cycles spent in MEM_WAIT before a memory error is declared (1..65535).
- CNT_W, 32: width of the performance counters.

- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- Rs1D, Rs2D  in  5  source registers of the instruction in Decode.
- Rs1E, Rs2E, RdE  in  5  source and destination registers in Execute.
- ResultSrcE  in  2  Execute result source; 2'b01 marks a load.
- PCSrcE  in  1  taken branch or jump resolved in Execute.
- RdM, RdW  in  5  destination registers in Memory and Writeback.
- RegWriteM, RegWriteW  in  1  register-write enables in Memory and Writeback.
- MemReqM  in  1  load or store present in the Memory stage.
- MemReadyM  in  1  data memory has completed the access this cycle.
- StallF, StallD, StallE, StallM  out  1  hold the PC, IF/ID, ID/EX and EX/MEM registers.
- FlushD, FlushE, FlushW  out  1  bubble the IF/ID, ID/EX and MEM/WB registers.
- ForwardAE, ForwardBE  out  2  operand select: 00 register file, 01 Writeback result, 10 Memory ALU result.
- mem_err  out  1  sticky memory-timeout error flag.
- stall_cycles, flush_count  out  CNT_W  performance counters.

## Operation
**States:** RUN, MEM_WAIT and ERR. The state resets to RUN.

- **RUN**
  - MemReqM & ~MemReadyM: go to MEM_WAIT and clear wait_cnt.
- **MEM_WAIT**
  - MemReadyM: go to RUN.
  - Otherwise, wait_cnt == MEM_TIMEOUT-1: go to ERR.
  - Otherwise: wait_cnt increments.
- **ERR:** terminal state; only rst_n leaves it. mem_err = (state==ERR).

**Hazard conditions:**
- memStall = (state!=ERR) & MemReqM & ~MemReadyM. This is the same in RUN and MEM_WAIT.
- lwStall = (ResultSrcE==2'b01) & (RdE!=0) & ((Rs1D==RdE) | (Rs2D==RdE)).

**Output priority, highest first:**
1. ERR: StallF/D/E/M=1, FlushW=1, FlushD/E=0.
2. memStall: StallF/D/E/M=1, FlushW=1, FlushD/E=0. A pending PCSrcE or lwStall is held off until the stall releases, because the Execute and Decode contents are frozen.
3. PCSrcE: FlushD=1, FlushE=1, all stalls 0. This also wins over a simultaneous lwStall, because the dependent instruction is squashed.
4. lwStall: StallF=1, StallD=1, FlushE=1.
5. Otherwise all outputs are 0.

**Forwarding (ForwardAE; ForwardBE is identical using Rs2E):**
- 10 if RegWriteM & RdM!=0 & RdM==Rs1E.
- Else 01 if RegWriteW & RdW!=0 & RdW==Rs1E.
- Else 00.
- The Memory stage wins when both match.

**Counters:**
- stall_cycles increments on every cycle with StallF=1. This includes ERR.
- flush_count increments on every cycle where item 3 fires.
- Both wrap modulo 2^CNT_W.

## Timing
- Stall, Flush and Forward outputs are combinational from the inputs and the current state, with zero-cycle latency.
- state, wait_cnt, mem_err and the counters are registered.
- While rst_n=0:
  - Forced outputs: FlushD=FlushE=FlushW=1, all stalls 0, Forward*=00.
  - Registered values on the next edge: state=RUN, wait_cnt=0, mem_err=0, stall_cycles=0, flush_count=0.
- A reset asserted mid-MEM_WAIT or in ERR returns to RUN on that edge.
- Memory wait: an access with MemReadyM first high in cycle N+k stalls exactly cycles N..N+k-1. Cycle N+k has no memStall.
- Timeout: ERR is entered on the edge ending the MEM_TIMEOUT-th consecutive not-ready cycle counted from MEM_WAIT entry. MemReadyM arriving in that same cycle wins, and the state goes to RUN.
- A load-use stall lasts exactly 1 cycle, unless extended by memStall.

## Test plan
- **Load-use:** lw x5 in Execute, Rs1D=5 -> one cycle of StallF=StallD=FlushE=1; stall_cycles +1. Repeat with RdE=0 -> no stall.
- **Forward priority:** RdM=RdW=Rs1E=7, both write enables high -> ForwardAE=10. Drop RegWriteM -> 01. Set Rs2E=0 with matches on x0 -> ForwardBE=00.
- **Branch + load-use in the same cycle:** PCSrcE=1, lwStall=1 -> FlushD=FlushE=1, StallF=0; flush_count +1.
- **Memory wait:** MemReqM=1, MemReadyM low for 3 cycles -> StallF/D/E/M=1 and FlushW=1 for exactly 3 cycles. A PCSrcE=1 held throughout yields FlushD=FlushE=0 until the 4th cycle, then flushes.
- **Timeout:** MEM_TIMEOUT=4, MemReadyM held low -> ERR and mem_err=1 after the 4th wait cycle; all stalls stay high. Pulse rst_n=0 -> next cycle RUN, mem_err=0, counters 0.
- **Counter wrap:** CNT_W=4, 16 stall cycles -> stall_cycles returns to 0.
